// File: rtl/ysyx_22040237_multi_cyc_seq_if.sv
// Instruction-memory fetch port: a valid/ready request channel carrying the PC
// and a valid-only response channel returning the fetched instruction word.
interface ysyx_22040237_multi_cyc_seq_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [ILEN-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/ysyx_22040237_multi_cyc_seq.sv
// Multi-cycle core sequencer: owns PC and the latched instruction, steps fetch/exec/mem/wb.
// Optional perf counters are built only when YSYX_22040237_PERF_CNT_EN is defined.
module ysyx_22040237_multi_cyc_seq #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned ILEN     = 32,
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned CNT_W    = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    ysyx_22040237_multi_cyc_seq_if.master        imem,
    output logic [XLEN-1:0]                      pc,
    output logic [ILEN-1:0]                      inst,
    input  logic                                 dec_is_mem,
    input  logic                                 dec_ebreak,
    input  logic                                 dec_invalid,
    input  logic                                 jump_flag,
    input  logic [XLEN-1:0]                      jump_addr,
    output logic                                 lsu_start,
    input  logic                                 lsu_done,
    output logic                                 wb_en,
    output logic                                 halted,
    output logic                                 trap,
    output logic [CNT_W-1:0]                     cycle_cnt,
    output logic [CNT_W-1:0]                     instret_cnt
);

    localparam logic [ILEN-1:0] NOP_INST = ILEN'(32'h0000_0013);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] inst_q, inst_d;
    logic            trap_q, trap_d;
    logic            mem_first_q, mem_first_d;
    logic            jump_misaligned;

    assign jump_misaligned = jump_flag && (jump_addr[1:0] != 2'b00);

    // The first MEM cycle is exactly the one entered from EXEC.
    assign mem_first_d = (state_q == S_EXEC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= XLEN'(RESET_PC);
            inst_q      <= NOP_INST;
            trap_q      <= 1'b0;
            mem_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            trap_q      <= trap_d;
            mem_first_q <= mem_first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:       state_d = S_FETCH_REQ;
            S_FETCH_REQ:  if (imem.req_ready) state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: if (imem.rsp_valid) state_d = S_EXEC;
            S_EXEC: begin
                if (dec_invalid || dec_ebreak) state_d = S_HALT;
                else if (dec_is_mem)           state_d = S_MEM;
                else                           state_d = S_WB;
            end
            S_MEM:        if (lsu_done) state_d = S_WB;
            S_WB:         state_d = jump_misaligned ? S_HALT : S_FETCH_REQ;
            S_HALT:       state_d = S_HALT;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        inst_d = inst_q;
        trap_d = trap_q;
        if (state_q == S_FETCH_WAIT && imem.rsp_valid) begin
            inst_d = imem.rsp_data;
        end
        if (state_q == S_EXEC && dec_invalid) begin
            trap_d = 1'b1;
        end
        if (state_q == S_WB) begin
            if (jump_misaligned)  trap_d = 1'b1;
            else if (jump_flag)   pc_d   = jump_addr;
            else                  pc_d   = pc_q + XLEN'(4);
        end
    end

    always_comb begin
        imem.req_valid = (state_q == S_FETCH_REQ);
        imem.req_addr  = pc_q;
        pc             = pc_q;
        inst           = inst_q;
        lsu_start      = (state_q == S_MEM) && mem_first_q;
        wb_en          = (state_q == S_WB) && !jump_misaligned;
        halted         = (state_q == S_HALT);
        trap           = trap_q;
    end

`ifdef YSYX_22040237_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (!halted) cycle_q   <= cycle_q + CNT_W'(1);
            if (wb_en)   instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
